fetch_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage fetch path.
- Drives the PC write enable and branch-select into the fetch stage.
- Drives the IF/ID write enable and the IF/ID, ID/EX and EX/MEM flush strobes.
- Resolves taken branches from MEM, load-use stalls from ID, and a HALT instruction detected in ID, with a drain-then-halt sequence and resume.

---
 rtl/fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencing controller for the 5-stage fetch path.
// Resolves MEM-stage taken branches, ID-stage load-use stalls and HALT
// instructions (drain, halt, resume), and drives PC / IF/ID enables and
// the IF/ID, ID/EX and EX/MEM flush strobes.
// Optional feature macro: FETCH_CTRL_PERF_EN adds stall_cycles and
// flush_events performance counters.
module fetch_ctrl #(
  parameter logic [5:0]  HALT_OPCODE  = 6'b111111,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MAX_STALL    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       branch_taken,
  input  logic       hazard_stall,
  input  logic [5:0] id_opcode,
  input  logic       resume,
  output logic       pc_write,
  output logic       pc_source,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       ifid_valid,
  output logic       halted,
  output logic       stall_timeout,
  output logic [1:0] state
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [2:0] DrainLoad  = 3'(DRAIN_CYCLES - 1);
  localparam logic [7:0] StallLimit = 8'(MAX_STALL);

  state_e     state_q, state_d;
  logic       ifid_valid_q, ifid_valid_d;
  logic [2:0] drain_cnt_q, drain_cnt_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic       stall_timeout_q, stall_timeout_d;
  logic       halt_det;

  assign halt_det = ifid_valid_q && (id_opcode == HALT_OPCODE);

  // Next-state and Mealy outputs; priority is branch > halt detect > stall.
  always_comb begin
    state_d         = state_q;
    ifid_valid_d    = ifid_valid_q;
    drain_cnt_d     = drain_cnt_q;
    stall_cnt_d     = stall_cnt_q;
    stall_timeout_d = stall_timeout_q;
    pc_write        = 1'b0;
    pc_source       = 1'b0;
    ifid_write      = 1'b0;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    exmem_flush     = 1'b0;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (state_q == HALT) begin
      ifid_flush   = 1'b1;
      ifid_valid_d = 1'b0;
      if (resume) state_d = RUN;
    end else if (branch_taken) begin
      pc_write     = 1'b1;
      pc_source    = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = 1'b1;
      ifid_valid_d = 1'b0;
      stall_cnt_d  = 8'd0;
      state_d      = RUN;
    end else if (state_q == DRAIN) begin
      ifid_flush   = 1'b1;
      ifid_valid_d = 1'b0;
      if (drain_cnt_q == 3'd0) state_d = HALT;
      else drain_cnt_d = drain_cnt_q - 3'd1;
    end else if (halt_det) begin
      ifid_write   = 1'b1;
      ifid_flush   = 1'b1;
      ifid_valid_d = 1'b0;
      drain_cnt_d  = DrainLoad;
      state_d      = DRAIN;
    end else if (hazard_stall && !(state_q == STALL && stall_cnt_q == StallLimit)) begin
      idex_flush  = 1'b1;
      stall_cnt_d = (state_q == RUN) ? 8'd1 : stall_cnt_q + 8'd1;
      state_d     = STALL;
    end else begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_valid_d = 1'b1;
      if (state_q == STALL && hazard_stall) stall_timeout_d = 1'b1;
      stall_cnt_d  = 8'd0;
      state_d      = RUN;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= RUN;
      ifid_valid_q    <= 1'b0;
      drain_cnt_q     <= 3'd0;
      stall_cnt_q     <= 8'd0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ifid_valid_q    <= ifid_valid_d;
      drain_cnt_q     <= drain_cnt_d;
      stall_cnt_q     <= stall_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign ifid_valid    = ifid_valid_q;
  assign halted        = (state_q == HALT);
  assign stall_timeout = stall_timeout_q;
  assign state         = state_q;

`ifdef FETCH_CTRL_PERF_EN
  logic        stall_bubble;
  logic        branch_cycle;
  logic [15:0] stall_cycles_q;
  logic [15:0] flush_events_q;

  // A stall bubble flushes ID/EX alone; a branch also flushes EX/MEM.
  assign stall_bubble = !reset && idex_flush && !exmem_flush;
  assign branch_cycle = !reset && exmem_flush;

  // Saturating performance counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= 16'd0;
      flush_events_q <= 16'd0;
    end else begin
      if (stall_bubble && stall_cycles_q != 16'hFFFF) stall_cycles_q <= stall_cycles_q + 16'd1;
      if (branch_cycle && flush_events_q != 16'hFFFF) flush_events_q <= flush_events_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by a
// randomized run, all compared against a behavioural reference model.
module tb_fetch_ctrl;

  logic       clk;
  logic       reset;
  logic       branch_taken;
  logic       hazard_stall;
  logic [5:0] id_opcode;
  logic       resume;
  logic       pc_write, pc_source, ifid_write;
  logic       ifid_flush, idex_flush, exmem_flush;
  logic       ifid_valid, halted, stall_timeout;
  logic [1:0] state;

  int nCompared = 0;
  int nMismatched = 0;
  int cycle = 0;

  // Reference model: mode 0 running, 1 stalled, 2 draining, 3 halted.
  int mMode;
  bit mValid;
  int mDrainLeft;
  int mStallRun;
  bit mTimeout;

  localparam int MaxStall = 8;
  localparam int DrainCycles = 3;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .branch_taken(branch_taken),
    .hazard_stall(hazard_stall), .id_opcode(id_opcode), .resume(resume),
    .pc_write(pc_write), .pc_source(pc_source), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .ifid_valid(ifid_valid), .halted(halted), .stall_timeout(stall_timeout),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check against the model, then advance it.
  task automatic applyStimulus(input bit r, input bit b, input bit h,
                               input logic [5:0] op, input bit res);
    bit ePw, ePs, eIw;
    bit [2:0] eFl;
    int nMode, nDrain, nStall;
    bit nValid, nTout;
    bit haltSeen;
    reset = r; branch_taken = b; hazard_stall = h; id_opcode = op; resume = res;
    @(negedge clk);
    ePw = 0; ePs = 0; eIw = 0; eFl = 3'b000;
    nMode = mMode; nValid = mValid; nDrain = mDrainLeft; nStall = mStallRun; nTout = mTimeout;
    haltSeen = mValid && (op == 6'h3F);
    if (r) begin
      eFl = 3'b111;
      nMode = 0; nValid = 0; nDrain = 0; nStall = 0; nTout = 0;
    end else if (mMode == 3) begin
      eFl = 3'b100;
      nValid = 0;
      if (res) nMode = 0;
    end else if (b) begin
      ePw = 1; ePs = 1; eIw = 1; eFl = 3'b111;
      nValid = 0; nStall = 0; nMode = 0;
    end else if (mMode == 2) begin
      eFl = 3'b100;
      nValid = 0;
      if (mDrainLeft == 1) nMode = 3;
      else nDrain = mDrainLeft - 1;
    end else if (haltSeen) begin
      eIw = 1; eFl = 3'b100;
      nValid = 0; nMode = 2; nDrain = DrainCycles;
    end else if (h && mStallRun < MaxStall) begin
      eFl = 3'b010;
      nStall = mStallRun + 1; nMode = 1;
    end else begin
      ePw = 1; eIw = 1;
      nValid = 1; nMode = 0; nStall = 0;
      if (h) nTout = 1;
    end
    checkOutput("pc_write",      {7'd0, pc_write},      {7'd0, ePw});
    checkOutput("pc_source",     {7'd0, pc_source},     {7'd0, ePs});
    checkOutput("ifid_write",    {7'd0, ifid_write},    {7'd0, eIw});
    checkOutput("flushes",       {5'd0, ifid_flush, idex_flush, exmem_flush}, {5'd0, eFl});
    if (mMode >= 0) begin
      checkOutput("state",         {6'd0, state},         8'(mMode));
      checkOutput("ifid_valid",    {7'd0, ifid_valid},    {7'd0, mValid});
      checkOutput("halted",        {7'd0, halted},        {7'd0, (mMode == 3)});
      checkOutput("stall_timeout", {7'd0, stall_timeout}, {7'd0, mTimeout});
    end
    @(posedge clk);
    mMode = nMode; mValid = nValid; mDrainLeft = nDrain; mStallRun = nStall; mTimeout = nTout;
    cycle++;
    #1;
  endtask

  task automatic runFree(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 6'h00, 0);
  endtask

  // Directed scenarios, then randomized traffic.
  initial begin
    reset = 1; branch_taken = 0; hazard_stall = 0; id_opcode = 6'h00; resume = 0;
    @(posedge clk); #1;
    mMode = 0; mValid = 0; mDrainLeft = 0; mStallRun = 0; mTimeout = 0;

    $display("[TB] reset then free run");
    applyStimulus(1, 0, 0, 6'h00, 0);
    runFree(4);

    $display("[TB] two-cycle hazard");
    applyStimulus(0, 0, 1, 6'h00, 0);
    applyStimulus(0, 0, 1, 6'h00, 0);
    runFree(3);

    $display("[TB] twelve-cycle hazard, timeout");
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 6'h00, 0);
    runFree(2);
    checkOutput("timeout_sticky", {7'd0, stall_timeout}, 8'd1);

    $display("[TB] branch with hazard and halt opcode");
    applyStimulus(0, 1, 1, 6'h3F, 0);
    runFree(3);

    $display("[TB] halt, drain, branch in halt, resume");
    applyStimulus(0, 0, 0, 6'h3F, 0);
    for (int i = 0; i < DrainCycles; i++) applyStimulus(0, 0, 1, 6'h3F, 0);
    checkOutput("halted_after_drain", {6'd0, state}, 8'd3);
    applyStimulus(0, 1, 1, 6'h00, 0);
    applyStimulus(0, 1, 0, 6'h00, 0);
    applyStimulus(0, 0, 0, 6'h00, 1);
    checkOutput("state_after_resume", {6'd0, state}, 8'd0);
    runFree(3);

    $display("[TB] halt aborted by branch in drain");
    applyStimulus(0, 0, 0, 6'h3F, 0);
    applyStimulus(0, 1, 0, 6'h00, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 6'h00, 0);
      checkOutput("no_halt_after_abort", {7'd0, halted}, 8'd0);
    end

    $display("[TB] reset mid-stall");
    applyStimulus(0, 0, 1, 6'h00, 0);
    applyStimulus(0, 0, 1, 6'h00, 0);
    applyStimulus(1, 0, 1, 6'h3F, 1);
    runFree(2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      bit rr, bb, hh, ss;
      logic [5:0] oo;
      rr = ($urandom_range(0, 99) < 2);
      bb = ($urandom_range(0, 99) < 10);
      hh = ($urandom_range(0, 99) < 45);
      ss = ($urandom_range(0, 99) < 25);
      oo = ($urandom_range(0, 99) < 12) ? 6'h3F : 6'($urandom_range(0, 62));
      applyStimulus(rr, bb, hh, oo, ss);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
